dly_ring_mon: RTL



---
 rtl/dly_ring_mon_if.sv | 23 ++
 rtl/dly_ring_mon.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dly_ring_mon_if.sv
// Control/result bundle for the ring-oscillator delay monitor.
// The master drives START/WINDOW; the slave returns status and the result.
interface dly_ring_mon_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             START;
  logic [WIN_W-1:0] WINDOW;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] COUNT;
  logic             OVF;

  modport master (
    output START, WINDOW,
    input  BUSY, DONE, COUNT, OVF
  );

  modport slave (
    input  START, WINDOW,
    output BUSY, DONE, COUNT, OVF
  );
endinterface

// File: rtl/dly_ring_mon.sv
// Ring-oscillator delay monitor: warm the ring up, then count
// synchronized RO rising edges over a gate of WINDOW clock cycles.
module dly_ring_mon #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RO,
  output logic          EN_RO,
  dly_ring_mon_if.slave bus
);

  localparam int TW = (WIN_W > 8) ? WIN_W : 8;
  localparam logic [TW-1:0]    SET_LAST = TW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    GATE
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             oflag_q, oflag_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             s1_q, s2_q, prev_q;
  logic             rise;
  logic [TW-1:0]    win_last;

  // RO is asynchronous: two flops to resolve metastability, one for edge detect
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= RO;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise     = s2_q & ~prev_q;
  assign win_last = TW'(win_q) - TW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      oflag_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      oflag_q <= oflag_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    win_d   = win_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    oflag_d = oflag_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          win_d   = bus.WINDOW;
          acc_d   = '0;
          oflag_d = 1'b0;
          tmr_d   = '0;
          state_d = WARM;
        end
      end
      WARM: begin
        if (tmr_q == SET_LAST) begin
          tmr_d = '0;
          if (win_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = acc_q;
            ovf_d   = oflag_q;
          end else begin
            state_d = GATE;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      GATE: begin
        if (rise) begin
          if (acc_q == ACC_MAX) oflag_d = 1'b1;
          else acc_d = acc_q + CNT_W'(1);
        end
        // the rise in the final gate cycle still belongs in the result
        if (tmr_q == win_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = acc_d;
          ovf_d   = oflag_d;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.BUSY  = (state_q != IDLE);
  assign EN_RO     = (state_q != IDLE);
  assign bus.DONE  = done_q;
  assign bus.COUNT = cnt_q;
  assign bus.OVF   = ovf_q;

endmodule
